pipe_if_icache: RTL and testbench
=================================

PIPE_IF_ICACHE -- requirements
Module: pipe_if_icache

Interface
REQ-001 SHALL have parameter INDEX_W, default 5, meaning log2 of icache line count (2^INDEX_W one-word lines).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream hold; PC must not advance
- pcsource  in  2  next-PC select: 0 pc4, 1 pc_jr, 2 pc_beqbne, 3 jump
- pc_jr  in  32  register-jump target
- pc_beqbne  in  32  branch target
- index28  in  28  jump index, already shifted left by 2
- inv_req  in  1  one-cycle pulse requesting full icache invalidate
- mem_req  out  1  external instruction-memory read request
- mem_addr  out  32  word-aligned read address
- mem_ack  in  1  read data valid, one-cycle pulse
- mem_rdata  in  32  read data
- pc  out  32  current fetch PC
- inst  out  32  instruction at pc
- inst_valid  out  1  inst is valid this cycle
- npc  out  32  selected next PC
- pc8  out  32  pc+8, link address
- inv_busy  out  1  invalidate sweep in progress

Function
REQ-004 SHALL hold the cache as direct-mapped: index = pc[INDEX_W+1:2], tag = pc[31:INDEX_W+2], per-line valid bit; pc[1:0] ignored.
REQ-005 SHALL compute pc4 = pc+4 and pc8 = pc+8 modulo 2^32 (wrap at 32'hFFFF_FFFC), and set npc = pc4/pc_jr/pc_beqbne/{pc[31:28],index28} for pcsource 0/1/2/3.
REQ-006 SHALL run FSM states LOOKUP, MISS, INVAL.
REQ-007 LOOKUP: hit (valid and tag match) -> inst_valid=1 with inst from array, combinationally, same cycle as pc (zero-cycle hit latency).
REQ-008 LOOKUP miss -> next cycle MISS; inst_valid=0 in that cycle.
REQ-009 MISS: mem_req=1, mem_addr={pc[31:2],2'b00}, both held stable until mem_ack; on mem_ack write mem_rdata, tag, valid=1 into line, return to LOOKUP (hits next cycle); miss penalty = ack latency + 2 cycles.
REQ-010 SHALL update pc <= npc only when inst_valid=1 and stall=0; otherwise pc holds; pcsource/targets sampled only in that advance cycle.
REQ-011 stall=1 during hit: inst, inst_valid and pc held stable.
REQ-012 inv_req in LOOKUP -> INVAL next cycle; inv_req in MISS -> recorded, current miss completes and fills, then INVAL instead of LOOKUP; inv_req in INVAL ignored.
REQ-013 INVAL: clear one valid bit per cycle, index 0 upward, 2^INDEX_W cycles total, inv_busy=1, inst_valid=0, mem_req=0; then LOOKUP.
REQ-014 mem_ack outside MISS SHALL be ignored.

Reset
REQ-015 rst=1 at a clock edge: pc=RESET_PC, state=LOOKUP, all valid bits cleared in that same cycle, pending inv cleared, mem_req=0, inv_busy=0 from next cycle; inst_valid=0 until first fill.
REQ-016 rst during MISS SHALL abandon the read; a later mem_ack SHALL be ignored unless a new MISS is active.

Configuration
REQ-017 Macro ICACHE_STATS_EN: defined -> add outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0, wrapping; hit_cnt +1 per advance cycle, miss_cnt +1 per LOOKUP->MISS transition; undefined -> ports and counters absent, behaviour otherwise identical.

Structure
REQ-018 Shared package SHALL hold FSM state encoding, pcsource codes (PCSRC_PC4, PCSRC_JR, PCSRC_BR, PCSRC_J) and RESET_PC default.
REQ-019 Tag/data/valid storage SHALL be one sub-module icache_array (combinational read, synchronous write, synchronous clear-by-index, clear-all on rst).

Verification
REQ-020 Reset, RESET_PC=0, mem_ack 3 cycles after mem_req -> mem_addr=0, inst_valid rises 5 cycles after reset release, pc then 4.
REQ-021 Sequential fetch 0..0x7C then loop back with pcsource=3, index28=0 -> second pass 32 consecutive hits, no mem_req.
REQ-022 INDEX_W=5, fetch 0x000 then 0x080 (same index) -> second access misses, refetch of 0x000 misses again.
REQ-023 stall=1 for 4 cycles on hit at pc=0x10 -> pc, inst constant; pcsource=2, pc_beqbne=0x200 on release -> pc=0x200 next cycle.
REQ-024 inv_req during MISS -> fill completes, inv_busy=1 for exactly 32 cycles, next fetch misses.
REQ-025 rst asserted mid-MISS, stale mem_ack 2 cycles later -> no line written, pc=RESET_PC, new miss issued.

Source files
------------

// File: rtl/pipe_if_icache_pkg.sv
// ============================================================================
// pipe_if_icache_pkg : shared FSM encoding, next-PC select codes, reset PC
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_if_icache_pkg;

  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,
    ST_MISS   = 2'd1,
    ST_INVAL  = 2'd2
  } state_t;

  localparam logic [1:0] PCSRC_PC4 = 2'd0;
  localparam logic [1:0] PCSRC_JR  = 2'd1;
  localparam logic [1:0] PCSRC_BR  = 2'd2;
  localparam logic [1:0] PCSRC_J   = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pipe_if_icache_array.sv
// ============================================================================
// icache_array : direct-mapped tag/data/valid storage, async read, sync write
// Revision: 1.0
// ============================================================================
`default_nettype none

module icache_array
  import pipe_if_icache_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data,
  input  logic               clr_en,
  input  logic [INDEX_W-1:0] clr_idx
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [31:0]      words [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (clr_en) valid[clr_idx] <= 1'b0;
      if (wr_en)  valid[wr_idx]  <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only trusted through its valid bit
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = words[rd_idx];

endmodule

`default_nettype wire

// File: rtl/pipe_if_icache.sv
// ============================================================================
// pipe_if_icache : IF stage with direct-mapped one-word-line icache.
// Optional ICACHE_STATS_EN adds hit_cnt / miss_cnt outputs.  Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_if_icache
  import pipe_if_icache_pkg::*;
#(
  parameter int          INDEX_W  = 5,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] pc_jr,
  input  logic [31:0] pc_beqbne,
  input  logic [27:0] index28,
  input  logic        inv_req,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] npc,
  output logic [31:0] pc8,
  output logic        inv_busy
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_W = 30 - INDEX_W;

  state_t             state;
  logic               inv_pend;
  logic [INDEX_W-1:0] inv_idx;
  logic [INDEX_W-1:0] line_idx;
  logic [TAG_W-1:0]   line_tag_pc;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [31:0]        line_data;
  logic               hit;
  logic               advance;
  logic               fill;
  logic [31:0]        pc4;

  assign line_idx    = pc[INDEX_W+1:2];
  assign line_tag_pc = pc[31:INDEX_W+2];
  assign hit         = (state == ST_LOOKUP) && line_valid && (line_tag == line_tag_pc);
  assign advance     = hit && !stall;
  assign fill        = (state == ST_MISS) && mem_ack && !rst;

  assign inst       = line_data;
  assign inst_valid = hit;
  assign inv_busy   = (state == ST_INVAL);
  assign mem_addr   = {pc[31:2], 2'b00};
  assign pc4        = pc + 32'd4;
  assign pc8        = pc + 32'd8;

  always_comb begin
    npc = pc4;
    case (pcsource)
      PCSRC_PC4: npc = pc4;
      PCSRC_JR:  npc = pc_jr;
      PCSRC_BR:  npc = pc_beqbne;
      PCSRC_J:   npc = {pc[31:28], index28};
      default:   npc = pc4;
    endcase
  end

  icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (line_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill),
    .wr_idx   (line_idx),
    .wr_tag   (line_tag_pc),
    .wr_data  (mem_rdata),
    .clr_en   (state == ST_INVAL),
    .clr_idx  (inv_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= ST_LOOKUP;
      inv_pend <= 1'b0;
      inv_idx  <= '0;
      mem_req  <= 1'b0;
    end else begin
      if (advance) pc <= npc;
      case (state)
        ST_LOOKUP: begin
          if (inv_req) begin
            state   <= ST_INVAL;
            inv_idx <= '0;
          end else if (!hit) begin
            state   <= ST_MISS;
            mem_req <= 1'b1;
          end
        end
        ST_MISS: begin
          if (inv_req) inv_pend <= 1'b1;
          // A pending invalidate waits for the fill so the bus read is never cut short
          if (mem_ack) begin
            mem_req  <= 1'b0;
            inv_pend <= 1'b0;
            inv_idx  <= '0;
            state    <= (inv_pend || inv_req) ? ST_INVAL : ST_LOOKUP;
          end
        end
        ST_INVAL: begin
          inv_idx <= inv_idx + INDEX_W'(1);
          if (&inv_idx) state <= ST_LOOKUP;
        end
        default: state <= ST_LOOKUP;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (advance) hit_cnt <= hit_cnt + 32'd1;
      if ((state == ST_LOOKUP) && !inv_req && !hit) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_if_icache.sv
// ============================================================================
// tb_pipe_if_icache : self-checking bench for pipe_if_icache against a
// transaction-level cache/PC model.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_if_icache;
  import pipe_if_icache_pkg::*;

  localparam int LINES = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pcsource = 2'd0;
  logic [31:0] pc_jr = '0;
  logic [31:0] pc_beqbne = '0;
  logic [27:0] index28 = '0;
  logic        inv_req = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] npc;
  logic [31:0] pc8;
  logic        inv_busy;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  pipe_if_icache #(.INDEX_W(5), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .pcsource   (pcsource),
    .pc_jr      (pc_jr),
    .pc_beqbne  (pc_beqbne),
    .index28    (index28),
    .inv_req    (inv_req),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .npc        (npc),
    .pc8        (pc8),
    .inv_busy   (inv_busy)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: which word address each line holds, plus the architectural PC
  bit          m_valid [LINES];
  logic [31:0] m_addr  [LINES];
  logic [31:0] m_pc;
  int          m_adv;
  int          m_miss;
  logic [31:0] salt;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    repeat (ncyc) step();
    rst = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_pc = 32'h0000_0000;
    m_adv = 0;
    m_miss = 0;
    checks++;
    if (pc !== 32'h0 || inst_valid !== 1'b0 || mem_req !== 1'b0 || inv_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h iv=%b req=%b busy=%b want pc=0 iv=0 req=0 busy=0",
               pc, inst_valid, mem_req, inv_busy);
    end
  endtask

  // One instruction fetched and retired: miss handling (if any), optional stalls, advance
  task automatic fetch(input logic [1:0] src, input logic [31:0] tgt, input int lat,
                       input int nstall, input bit spur, output bit was_miss);
    logic [31:0] a;
    logic [31:0] want;
    int ix;
    a  = {m_pc[31:2], 2'b00};
    ix = int'((a >> 2) % LINES);
    was_miss = !(m_valid[ix] && m_addr[ix] == a);
    if (spur) begin
      mem_ack = 1'b1;
      mem_rdata = ~mem_word(a);
    end
    if (was_miss) begin
      m_miss++;
      checks++;
      if (inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL miss_cycle0 pc=%h inst_valid=%b want 0", m_pc, inst_valid);
      end
      step();
      mem_ack = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== a) begin
        errors++;
        $display("FAIL miss_req req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, a);
      end
      for (int k = 0; k < lat; k++) begin
        step();
        checks++;
        if (mem_req !== 1'b1 || inst_valid !== 1'b0 || pc !== m_pc) begin
          errors++;
          $display("FAIL miss_hold req=%b iv=%b pc=%h want req=1 iv=0 pc=%h",
                   mem_req, inst_valid, pc, m_pc);
        end
      end
      mem_ack = 1'b1;
      mem_rdata = mem_word(a);
      step();
      mem_ack = 1'b0;
      mem_rdata = $urandom();
      m_valid[ix] = 1'b1;
      m_addr[ix] = a;
    end
    checks++;
    if (inst_valid !== 1'b1 || inst !== mem_word(a) || mem_req !== 1'b0 || pc !== m_pc) begin
      errors++;
      $display("FAIL hit pc=%h iv=%b inst=%h req=%b want pc=%h iv=1 inst=%h req=0",
               pc, inst_valid, inst, mem_req, m_pc, mem_word(a));
    end
    for (int s = 0; s < nstall; s++) begin
      stall = 1'b1;
      pcsource = 2'($urandom());
      pc_jr = $urandom();
      pc_beqbne = $urandom();
      index28 = 28'($urandom());
      step();
      mem_ack = 1'b0;
      checks++;
      if (pc !== m_pc || inst_valid !== 1'b1 || inst !== mem_word(a)) begin
        errors++;
        $display("FAIL stall_hold pc=%h iv=%b inst=%h want pc=%h iv=1 inst=%h",
                 pc, inst_valid, inst, m_pc, mem_word(a));
      end
    end
    stall = 1'b0;
    pcsource = src;
    pc_jr = $urandom();
    pc_beqbne = $urandom();
    index28 = 28'($urandom());
    case (src)
      PCSRC_JR: begin pc_jr = tgt; want = tgt; end
      PCSRC_BR: begin pc_beqbne = tgt; want = tgt; end
      PCSRC_J:  begin index28 = tgt[27:0]; want = {m_pc[31:28], tgt[27:0]}; end
      default:  want = m_pc + 32'd4;
    endcase
    #1;
    checks++;
    if (npc !== want || pc8 !== m_pc + 32'd8) begin
      errors++;
      $display("FAIL next_pc npc=%h pc8=%h want npc=%h pc8=%h", npc, pc8, want, m_pc + 32'd8);
    end
    step();
    mem_ack = 1'b0;
    m_adv++;
    m_pc = want;
    checks++;
    if (pc !== m_pc) begin
      errors++;
      $display("FAIL advance pc=%h want %h", pc, m_pc);
    end
  endtask

  task automatic test_reset();
    bit m;
    do_reset(1);
    fetch(PCSRC_PC4, 32'h0, 3, 0, 1'b0, m);
    checks++;
    if (!m || pc !== 32'h4) begin
      errors++;
      $display("FAIL first_fetch miss=%b pc=%h want miss=1 pc=00000004", m, pc);
    end
  endtask

  task automatic test_sequential();
    bit m;
    int misses;
    do_reset(1);
    for (int pass = 0; pass < 2; pass++) begin
      misses = 0;
      for (int i = 0; i < 32; i++) begin
        fetch((i == 31) ? PCSRC_J : PCSRC_PC4, 32'h0, int'($urandom_range(1, 4)), 0, 1'b0, m);
        if (m) misses++;
      end
      checks++;
      if (misses != ((pass == 0) ? 32 : 0)) begin
        errors++;
        $display("FAIL seq_pass%0d misses=%0d want %0d", pass, misses, (pass == 0) ? 32 : 0);
      end
    end
  endtask

  task automatic test_conflict();
    bit m0, m1, m2;
    do_reset(1);
    fetch(PCSRC_J, 32'h080, 2, 0, 1'b0, m0);
    fetch(PCSRC_J, 32'h000, 2, 0, 1'b0, m1);
    fetch(PCSRC_PC4, 32'h0, 2, 0, 1'b0, m2);
    checks++;
    if (!(m0 && m1 && m2)) begin
      errors++;
      $display("FAIL conflict misses=%b%b%b want 111", m0, m1, m2);
    end
  endtask

  task automatic test_stall();
    bit m;
    do_reset(1);
    for (int i = 0; i < 4; i++) fetch(PCSRC_PC4, 32'h0, 1, 0, 1'b0, m);
    fetch(PCSRC_J, 32'h010, 1, 0, 1'b0, m);
    fetch(PCSRC_BR, 32'h200, 1, 4, 1'b0, m);
    checks++;
    if (m || pc !== 32'h200) begin
      errors++;
      $display("FAIL stall_branch miss=%b pc=%h want miss=0 pc=00000200", m, pc);
    end
  endtask

  task automatic test_inval_during_miss();
    logic [31:0] a;
    int n;
    bit m;
    a = m_pc;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL inval_miss_start iv=%b want 0", inst_valid);
    end
    step();
    inv_req = 1'b1;
    step();
    inv_req = 1'b0;
    step();
    mem_ack = 1'b1;
    mem_rdata = mem_word(a);
    step();
    mem_ack = 1'b0;
    m_miss++;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    n = 0;
    while (inv_busy === 1'b1 && n < 40) begin
      checks++;
      if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL inval_quiet iv=%b req=%b want 0 0", inst_valid, mem_req);
      end
      n++;
      step();
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL inval_len busy_cycles=%0d want 32", n);
    end
    fetch(PCSRC_PC4, 32'h0, 2, 0, 1'b0, m);
    checks++;
    if (!m) begin
      errors++;
      $display("FAIL inval_refetch miss=%b want 1", m);
    end
  endtask

  task automatic test_reset_mid_miss();
    bit m0, m1;
    fetch(PCSRC_J, 32'h344, 1, 0, 1'b0, m0);
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmm_lookup iv=%b want 0", inst_valid);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h344) begin
      errors++;
      $display("FAIL rmm_req req=%b addr=%h want 1 00000344", mem_req, mem_addr);
    end
    do_reset(2);
    fetch(PCSRC_J, 32'h344, 2, 0, 1'b1, m0);
    fetch(PCSRC_PC4, 32'h0, 2, 0, 1'b0, m1);
    checks++;
    if (!m0 || !m1) begin
      errors++;
      $display("FAIL rmm_refetch misses=%b%b want 11", m0, m1);
    end
  endtask

  task automatic test_wrap();
    bit m;
    fetch(PCSRC_JR, 32'hFFFF_FFFC, 1, 0, 1'b0, m);
    fetch(PCSRC_PC4, 32'h0, 1, 0, 1'b0, m);
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap pc=%h want 00000000", pc);
    end
  endtask

  task automatic test_random();
    bit m;
    logic [31:0] tgt;
    logic [1:0] src;
    for (int i = 0; i < 150; i++) begin
      src = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) tgt = $urandom() & 32'hFFFF_FFFC;
      else tgt = 32'($urandom_range(0, 255)) << 2;
      fetch(src, tgt, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 4) == 0), m);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    salt = $urandom();
    test_reset();
    test_sequential();
    test_conflict();
    test_stall();
    test_inval_during_miss();
    test_reset_mid_miss();
    test_wrap();
    test_random();
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_cnt !== 32'(m_adv) || miss_cnt !== 32'(m_miss)) begin
      errors++;
      $display("FAIL stats hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt, m_adv, m_miss);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
